// File: rtl/quad_step_decoder.sv
// quad_step_decoder
//   Turns 2-phase quadrature inputs (A/B) into single-cycle step pulses and a
//   direction flag for a downstream up/down counter. Illegal transitions,
//   where both phases change in one sample, produce an err pulse and are
//   counted in a saturating 8-bit counter with a sticky flag.
//   Optional build macro: QDEC_FILTER_EN adds a per-phase glitch filter between
//   the synchronizers and the decoder and lengthens the prime phase to match.
module quad_step_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_in,
  input  logic       b_in,
  input  logic       err_clr,
  output logic       step,
  output logic       up,
  output logic       err,
  output logic       err_flag,
  output logic [7:0] err_cnt
);

  // The prime counter is sized for the longest prime phase of either build.
  localparam int PRIME_W = $clog2(SYNC_STAGES + FILT_LEN + 2);
`ifdef QDEC_FILTER_EN
  localparam int PRIME_LEN = SYNC_STAGES + FILT_LEN + 1;
`else
  localparam int PRIME_LEN = SYNC_STAGES + 1;
`endif

  logic [SYNC_STAGES-1:0] r_sync_a;
  logic [SYNC_STAGES-1:0] r_sync_b;
  logic [1:0]             w_raw;
  logic [1:0]             w_q;
  logic [1:0]             r_prev;
  logic [PRIME_W-1:0]     r_prime_cnt;
  logic                   w_prime;
  logic                   w_step;
  logic                   w_err;
  logic                   w_dir;
  logic                   w_new_err;
  logic                   r_step;
  logic                   r_up;
  logic                   r_err;
  logic                   r_err_flag;
  logic [7:0]             r_err_cnt;

  // Two-or-more flop synchronizers bring each asynchronous phase into clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_a <= '0;
      r_sync_b <= '0;
    end else begin
      r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], a_in};
      r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], b_in};
    end
  end

  assign w_raw = {r_sync_a[SYNC_STAGES-1], r_sync_b[SYNC_STAGES-1]};

`ifdef QDEC_FILTER_EN
  logic [1:0] r_filt;
  logic [3:0] r_fcnt [2];

  // Each phase's filtered value flips only after FILT_LEN consecutive samples
  // that disagree with it; any agreeing sample restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt <= '0;
      for (int i = 0; i < 2; i++) r_fcnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_raw[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] + 4'd1 == 4'(FILT_LEN)) begin
          r_filt[i] <= w_raw[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + 4'd1;
        end
      end
    end
  end

  assign w_q = r_filt;
`else
  assign w_q = w_raw;
`endif

  assign w_prime = (r_prime_cnt < PRIME_W'(PRIME_LEN));

  // Classify the transition prev -> q as an up step, down step, error or idle.
  always_comb begin
    w_step = 1'b0;
    w_err  = 1'b0;
    w_dir  = r_up;
    case ({r_prev, w_q})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: begin
        w_step = 1'b1;
        w_dir  = 1'b1;
      end
      4'b0010, 4'b1011, 4'b1101, 4'b0100: begin
        w_step = 1'b1;
        w_dir  = 1'b0;
      end
      4'b0011, 4'b1100, 4'b0110, 4'b1001: w_err = 1'b1;
      default: ;
    endcase
  end

  assign w_new_err = w_err && !w_prime;

  // Track the previous state and run the post-reset prime phase, during which
  // prev follows q silently so the power-up input level never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev      <= 2'b00;
      r_prime_cnt <= '0;
    end else begin
      r_prev <= w_q;
      if (w_prime) r_prime_cnt <= r_prime_cnt + 1'b1;
    end
  end

  // Registered step/err pulses; direction only moves together with a step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step <= 1'b0;
      r_err  <= 1'b0;
      r_up   <= 1'b1;
    end else begin
      r_step <= w_step && !w_prime;
      r_err  <= w_new_err;
      if (w_step && !w_prime) r_up <= w_dir;
    end
  end

  // Sticky flag and saturating count; a new error beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_flag <= 1'b0;
      r_err_cnt  <= 8'd0;
    end else if (w_new_err) begin
      r_err_flag <= 1'b1;
      if (err_clr)                 r_err_cnt <= 8'd1;
      else if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end else if (err_clr) begin
      r_err_flag <= 1'b0;
      r_err_cnt  <= 8'd0;
    end
  end

  assign step     = r_step;
  assign up       = r_up;
  assign err      = r_err;
  assign err_flag = r_err_flag;
  assign err_cnt  = r_err_cnt;

endmodule
